// File: rtl/ps2_pkg.sv
// ps2_pkg: PS/2 frame constants and receive state encoding shared across the link.
package ps2_pkg;
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} ps2_rx_state_t;
  localparam int PS2_DATA_BITS = 8;
  localparam int PS2_FRAME_BITS = 11;
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchroniser plus run-length glitch filter for one PS/2 line.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic line,
  output logic level,
  output logic fall
);
  localparam int CW = $clog2(FILTER_LEN);
  logic s1, s2;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      level <= 1'b1;
      cnt <= '0;
      fall <= 1'b0;
    end else begin
      s1 <= line;
      s2 <= s1;
      fall <= 1'b0;
      if (s2 == level)
        cnt <= '0;
      else if (cnt == CW'(FILTER_LEN - 1)) begin
        level <= ~level;
        cnt <= '0;
        fall <= level;
      end else
        cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: rebuilds 11-bit PS/2 device-to-host frames and strobes out validated bytes.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ps2_clk_in,
  input  logic                     ps2_dat_in,
  input  logic                     rx_enable,
  output logic [PS2_DATA_BITS-1:0] data,
  output logic                     data_valid,
  output logic                     parity_error,
  output logic                     frame_error,
  output logic                     busy
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  ps2_rx_state_t state, state_n;
  logic [2:0] bit_cnt, bit_n;
  logic [PS2_DATA_BITS-1:0] shreg, sh_n, data_n;
  logic par, par_n, dv_n, pe_n, fer_n, good;
  logic [TW-1:0] tmo, tmo_n;
  logic [1:0] dat_sync;
  logic dat, fall, ps2_clk_lvl;
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk(clk),
    .reset(reset),
    .line(ps2_clk_in),
    .level(ps2_clk_lvl),
    .fall(fall)
  );
  assign dat = dat_sync[1];
  assign busy = state != RX_IDLE;
  assign good = ^{shreg, par};
  always_comb begin
    state_n = state;
    bit_n = bit_cnt;
    sh_n = shreg;
    par_n = par;
    data_n = data;
    dv_n = 1'b0;
    pe_n = 1'b0;
    fer_n = 1'b0;
    tmo_n = (state == RX_IDLE || fall) ? '0 : tmo + 1'b1;
    if (!rx_enable) begin
      state_n = RX_IDLE;
      bit_n = '0;
      tmo_n = '0;
    end else if (fall) begin
      case (state)
        RX_IDLE: begin
          state_n = dat ? RX_IDLE : RX_DATA;
          bit_n = '0;
        end
        RX_DATA: begin
          sh_n = {dat, shreg[PS2_DATA_BITS-1:1]};
          bit_n = bit_cnt + 3'd1;
          state_n = (bit_cnt == 3'(PS2_DATA_BITS - 1)) ? RX_PARITY : RX_DATA;
        end
        RX_PARITY: begin
          par_n = dat;
          state_n = RX_STOP;
        end
        RX_STOP: begin
          state_n = RX_IDLE;
          fer_n = !dat;
          pe_n = dat && !good;
          dv_n = dat && good;
          data_n = (dat && good) ? shreg : data;
        end
      endcase
    end else if (busy && tmo == TW'(TIMEOUT_CYCLES - 1)) begin
      // the device stalled mid-frame; drop the partial byte
      state_n = RX_IDLE;
      fer_n = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RX_IDLE;
      bit_cnt <= '0;
      shreg <= '0;
      par <= 1'b0;
      data <= '0;
      data_valid <= 1'b0;
      parity_error <= 1'b0;
      frame_error <= 1'b0;
      tmo <= '0;
      dat_sync <= 2'b11;
    end else begin
      state <= state_n;
      bit_cnt <= bit_n;
      shreg <= sh_n;
      par <= par_n;
      data <= data_n;
      data_valid <= dv_n;
      parity_error <= pe_n;
      frame_error <= fer_n;
      tmo <= tmo_n;
      dat_sync <= {dat_sync[0], ps2_dat_in};
    end
  end
endmodule
